// File: rtl/yuv2rgb_csc_pkg.sv
`default_nettype none
// ============================================================================
// yuv2rgb_csc_pkg : shared FSM states and CSC fixed-point coefficients
// Revision 1.0
// ============================================================================
package yuv2rgb_csc_pkg;

    typedef enum logic [2:0] {
        S_TOP_IDLE         = 3'd0,
        S_TOP_FETCH        = 3'd1,
        S_COLOR_CONVERSION = 3'd2,
        S_TOP_WRITE        = 3'd3
    } state_top;

    typedef enum logic [2:0] {
        S_CSC_IDLE = 3'd0,
        S_CSC_M0   = 3'd1,
        S_CSC_M1   = 3'd2,
        S_CSC_M2   = 3'd3,
        S_CSC_M3   = 3'd4,
        S_CSC_M4   = 3'd5,
        S_CSC_CLIP = 3'd6,
        S_CSC_OUT  = 3'd7
    } state_csc;

    // Coefficients scaled by 2^16
    localparam logic signed [31:0] C_Y  = 32'sd76284;
    localparam logic signed [31:0] C_RV = 32'sd104595;
    localparam logic signed [31:0] C_GU = 32'sd25624;
    localparam logic signed [31:0] C_GV = 32'sd53281;
    localparam logic signed [31:0] C_BU = 32'sd132251;

endpackage
`default_nettype wire

// File: rtl/yuv2rgb_csc_if.sv
`default_nettype none
// ============================================================================
// yuv2rgb_csc_if : YUV pixel input and RGB pixel output handshakes
// Revision 1.0
// ============================================================================
interface yuv2rgb_csc_if;
    logic       pix_valid_i;
    logic       pix_ready_o;
    logic [7:0] Y_i;
    logic [7:0] U_i;
    logic [7:0] V_i;
    logic       rgb_valid_o;
    logic       rgb_ready_i;
    logic [7:0] R_o;
    logic [7:0] G_o;
    logic [7:0] B_o;

    modport slave (
        input  pix_valid_i, Y_i, U_i, V_i, rgb_ready_i,
        output pix_ready_o, rgb_valid_o, R_o, G_o, B_o
    );

    modport master (
        output pix_valid_i, Y_i, U_i, V_i, rgb_ready_i,
        input  pix_ready_o, rgb_valid_o, R_o, G_o, B_o
    );
endinterface
`default_nettype wire

// File: rtl/yuv2rgb_csc_rgb_clip.sv
`default_nettype none
// ============================================================================
// yuv2rgb_csc_rgb_clip : signed 32-bit fixed-point to 8-bit saturating clip
// Revision 1.0
// ============================================================================
module yuv2rgb_csc_rgb_clip #(
    parameter int FRAC_BITS = 16
) (
    input  logic signed [31:0] acc_i,
    output logic        [7:0]  pix_o
);
    // Fraction bits are truncated, never rounded
    logic unused_frac;
    assign unused_frac = ^acc_i[FRAC_BITS-1:0];

    always_comb begin
        if (acc_i[31]) begin
            pix_o = 8'd0;
        end else if (|acc_i[30:FRAC_BITS+8]) begin
            pix_o = 8'hFF;
        end else begin
            pix_o = acc_i[FRAC_BITS+7:FRAC_BITS];
        end
    end
endmodule
`default_nettype wire

// File: rtl/yuv2rgb_csc.sv
`default_nettype none
// ============================================================================
// yuv2rgb_csc : YUV to RGB conversion using one time-shared 32x32 multiplier
// Revision 1.0
// ============================================================================
module yuv2rgb_csc
    import yuv2rgb_csc_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic          CLOCK_50_I,
    input  logic          resetn,
    yuv2rgb_csc_if.slave  csc
);
    state_csc           state_q, state_d;
    logic signed [31:0] y_q, y_d, u_q, u_d, v_q, v_d;
    logic signed [31:0] acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
    logic        [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic               rgb_valid_q, rgb_valid_d;

    logic signed [31:0] mul_coef, mul_opnd, prod;
    logic        [7:0]  clip_r, clip_g, clip_b;

    // Operand mux: the state selects which of the five products is formed
    always_comb begin
        mul_coef = 32'sd0;
        mul_opnd = 32'sd0;
        case (state_q)
            S_CSC_M0: begin mul_coef = C_Y;  mul_opnd = y_q; end
            S_CSC_M1: begin mul_coef = C_RV; mul_opnd = v_q; end
            S_CSC_M2: begin mul_coef = C_GU; mul_opnd = u_q; end
            S_CSC_M3: begin mul_coef = C_GV; mul_opnd = v_q; end
            S_CSC_M4: begin mul_coef = C_BU; mul_opnd = u_q; end
            default:  begin mul_coef = 32'sd0; mul_opnd = 32'sd0; end
        endcase
    end

    assign prod = mul_coef * mul_opnd;

    yuv2rgb_csc_rgb_clip #(.FRAC_BITS(FRAC_BITS)) u_clip_r (.acc_i(acc_r_q), .pix_o(clip_r));
    yuv2rgb_csc_rgb_clip #(.FRAC_BITS(FRAC_BITS)) u_clip_g (.acc_i(acc_g_q), .pix_o(clip_g));
    yuv2rgb_csc_rgb_clip #(.FRAC_BITS(FRAC_BITS)) u_clip_b (.acc_i(acc_b_q), .pix_o(clip_b));

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        u_d         = u_q;
        v_d         = v_q;
        acc_r_d     = acc_r_q;
        acc_g_d     = acc_g_q;
        acc_b_d     = acc_b_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        rgb_valid_d = rgb_valid_q;
        case (state_q)
            S_CSC_IDLE: begin
                if (csc.pix_valid_i) begin
                    y_d     = $signed({24'd0, csc.Y_i}) - 32'sd16;
                    u_d     = $signed({24'd0, csc.U_i}) - 32'sd128;
                    v_d     = $signed({24'd0, csc.V_i}) - 32'sd128;
                    state_d = S_CSC_M0;
                end
            end
            S_CSC_M0: begin
                acc_r_d = prod;
                acc_g_d = prod;
                acc_b_d = prod;
                state_d = S_CSC_M1;
            end
            S_CSC_M1: begin
                acc_r_d = acc_r_q + prod;
                state_d = S_CSC_M2;
            end
            S_CSC_M2: begin
                acc_g_d = acc_g_q - prod;
                state_d = S_CSC_M3;
            end
            S_CSC_M3: begin
                acc_g_d = acc_g_q - prod;
                state_d = S_CSC_M4;
            end
            S_CSC_M4: begin
                acc_b_d = acc_b_q + prod;
                state_d = S_CSC_CLIP;
            end
            S_CSC_CLIP: begin
                r_d         = clip_r;
                g_d         = clip_g;
                b_d         = clip_b;
                rgb_valid_d = 1'b1;
                state_d     = S_CSC_OUT;
            end
            S_CSC_OUT: begin
                if (csc.rgb_ready_i) begin
                    rgb_valid_d = 1'b0;
                    state_d     = S_CSC_IDLE;
                end
            end
            default: state_d = S_CSC_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_CSC_IDLE;
            y_q         <= 32'sd0;
            u_q         <= 32'sd0;
            v_q         <= 32'sd0;
            acc_r_q     <= 32'sd0;
            acc_g_q     <= 32'sd0;
            acc_b_q     <= 32'sd0;
            r_q         <= 8'd0;
            g_q         <= 8'd0;
            b_q         <= 8'd0;
            rgb_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            u_q         <= u_d;
            v_q         <= v_d;
            acc_r_q     <= acc_r_d;
            acc_g_q     <= acc_g_d;
            acc_b_q     <= acc_b_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            rgb_valid_q <= rgb_valid_d;
        end
    end

    assign csc.pix_ready_o = (state_q == S_CSC_IDLE);
    assign csc.rgb_valid_o = rgb_valid_q;
    assign csc.R_o         = r_q;
    assign csc.G_o         = g_q;
    assign csc.B_o         = b_q;
endmodule
`default_nettype wire

// File: doc/yuv2rgb_csc.md
# yuv2rgb_csc

Colour-space conversion engine for the image decoder. It consumes one upsampled YUV pixel (8-bit Y, U, V) and produces one clipped 8-bit RGB pixel. It sits between the U/V interpolation/SRAM-fetch logic in the top-level `S_COLOR_CONVERSION` flow and the RGB write-back to SRAM at `RED_OFFSET`, `GREEN_*_OFFSET` and `BLUE_*_OFFSET`. To fit the design's DSP budget, a single time-shared 32x32 signed multiplier computes all five products.

## Interface
Parameters:
- `FRAC_BITS`, default 16: fixed-point fraction width of the coefficients; the final right shift.

Ports:
- `CLOCK_50_I`  in  1  50 MHz system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `pix_valid_i`  in  1  a YUV pixel is presented.
- `pix_ready_o`  out  1  block can accept a pixel; combinational, `state == S_CSC_IDLE`.
- `Y_i`, `U_i`, `V_i`  in  8 each  unsigned pixel components.
- `rgb_valid_o`  out  1  `R_o`/`G_o`/`B_o` are valid; registered.
- `rgb_ready_i`  in  1  the consumer takes the RGB pixel.
- `R_o`, `G_o`, `B_o`  out  8 each  clipped RGB result; registered.

## Operation
- Coefficients are signed 32-bit: C_Y=76284, C_RV=104595, C_GU=25624, C_GV=53281, C_BU=132251.
- The transfer is R=C_Y·Y' + C_RV·V'; G=C_Y·Y' − C_GU·U' − C_GV·V'; B=C_Y·Y' + C_BU·U'.
- Y'=Y−16 and U'/V'=U/V−128, each sign-extended to 32 bits.
- Accumulators `acc_r`, `acc_g`, `acc_b` are signed 32-bit. With 8-bit inputs they cannot overflow: range is about ±3.6e7.
- Clipping uses the accumulator value:
  - if acc[31]=1, output 0;
  - else if any bit in acc[30:FRAC_BITS+8] is set, output 255;
  - else output acc[FRAC_BITS+7:FRAC_BITS].
- The FSM is `state_csc`. Each multiply state drives the operands of the one multiplier:
  - `S_CSC_IDLE`: if `pix_valid_i`, capture Y', U', V' and go to `S_CSC_M0`.
  - `S_CSC_M0`: compute C_Y·Y'; load it into all three accumulators.
  - `S_CSC_M1`: acc_r += C_RV·V'.
  - `S_CSC_M2`: acc_g −= C_GU·U'.
  - `S_CSC_M3`: acc_g −= C_GV·V'.
  - `S_CSC_M4`: acc_b += C_BU·U'.
  - `S_CSC_CLIP`: clip all three accumulators into `R_o`, `G_o`, `B_o`; set `rgb_valid_o`=1; go to `S_CSC_OUT`.
  - `S_CSC_OUT`: hold the outputs. If `rgb_ready_i`, clear `rgb_valid_o` and go to `S_CSC_IDLE`.
- Only one pixel is in flight at a time. There is no input buffering.
- Inputs are sampled only at the accept edge. Changes to `Y_i`, `U_i`, `V_i` afterwards are ignored.
- An undefined state goes to `S_CSC_IDLE`.

## Timing
- Reset state:
  - state `S_CSC_IDLE`;
  - `rgb_valid_o`=0;
  - `R_o`, `G_o`, `B_o`=0;
  - accumulators and operand registers = 0;
  - `pix_ready_o` reads 1 during reset, but no transfer occurs.
- Accept happens at edge t, when `pix_valid_i` && `pix_ready_o`.
- Products M0..M4 register at edges t+1..t+5.
- Outputs register at t+6. `rgb_valid_o` is high from edge t+6: latency 6 cycles.
- With `rgb_ready_i` held at 1, `rgb_valid_o` is high for exactly one cycle. The block returns to IDLE at t+7, and the next accept is at t+8 at the earliest: throughput 1 pixel per 8 cycles.
- Backpressure: `rgb_valid_o` and the RGB values stay stable until the `rgb_ready_i` edge. `pix_ready_o` stays 0 the whole time.
- `pix_valid_i` asserted outside IDLE is ignored; the upstream stage must hold it.
- Reset asserted mid-conversion aborts the conversion immediately and asynchronously. The partial pixel is discarded and no `rgb_valid_o` pulse follows.

## Structure
- Put the `state_csc` enum in the shared state header next to `state_top`.
- Put the five coefficient constants in a shared `csc_pkg`, so the bench and RTL use identical values.
- One natural sub-module: `rgb_clip`, a combinational 32-bit signed to 8-bit saturating clip parameterised by `FRAC_BITS`. Instantiate it three times.
- The multiplier is a single inferred `*` on muxed signed operands, selected by state.

## Test plan
- Y=16, U=128, V=128 → RGB=(0,0,0) with `rgb_valid_o` rising exactly 6 cycles after accept.
- Y=235, U=128, V=128 → (254,254,254).
- Y=255, U=255, V=255 → (255,125,255), exercising upper saturation on R and B.
- Y=0, U=0, V=0 → (0,135,0), exercising negative clamp on R and B.
- Backpressure: hold `rgb_ready_i`=0 for 20 cycles.
  - Outputs and `rgb_valid_o` stay stable.
  - `pix_ready_o` stays 0.
  - A `pix_valid_i` pixel presented meanwhile is accepted only after release.
- Mid-conversion reset: assert `resetn`=0 in `S_CSC_M2`. Outputs become 0 and `rgb_valid_o`=0 immediately, with no output pulse after release. The next pixel converts correctly. Back-to-back streaming of 100 random pixels matches the reference model at 8 cycles per pixel.
